pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 24, width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 2_700_000, cycles without a valid edge before loss of signal (100 ms at 27 MHz).
REQ-003 clk  input  1  system clock, 27 MHz; the block SHALL use one clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-006 meas_valid  output  1  one-cycle pulse when high_cnt/period_cnt update.
REQ-007 high_cnt  output  CNT_W  high time of the last complete period, in clk cycles.
REQ-008 period_cnt  output  CNT_W  length of the last complete period, rising edge to rising edge, in clk cycles.
REQ-009 duty_q8  output  8  floor(high_cnt*256/period_cnt).
REQ-010 duty_valid  output  1  one-cycle pulse when duty_q8 updates.
REQ-011 signal_ok  output  1  high while periodic edges are arriving within TIMEOUT.
REQ-012 stuck_level  output  1  synchronized pwm_in level at the last timeout.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer; edges are detected on the synchronized level against its 1-cycle delayed copy.
REQ-014 FSM states SHALL be IDLE, HIGH, LOW.
- IDLE: wait for first rising edge -> HIGH; no measurement is produced.
- HIGH: falling edge -> LOW, latch high count.
- LOW: rising edge -> HIGH, latch period, pulse meas_valid.
REQ-015 On each rising-edge cycle the running counter SHALL load 1 and then increment once per cycle, so period_cnt equals the exact cycle distance between rising edges.
REQ-016 high_cnt SHALL equal the cycle distance from a rising edge to the following falling edge.
REQ-017 meas_valid SHALL assert in the cycle after the detected rising edge that closes the period, with high_cnt and period_cnt updated in that same cycle.
REQ-018 Running counters SHALL saturate at all-ones and never wrap.
REQ-019 If the running counter reaches TIMEOUT in HIGH or LOW, the FSM SHALL go to IDLE, deassert signal_ok, and load stuck_level with the current synchronized level.
- This covers 0 % and 100 % duty.
- high_cnt and period_cnt SHALL hold their last values.
REQ-020 signal_ok SHALL set on the first meas_valid after IDLE and clear only on timeout or reset.
REQ-021 Each meas_valid SHALL start the divider on (high_cnt<<8)/period_cnt.
- Restoring algorithm, 1 quotient bit per cycle.
- duty_valid asserts exactly 9 cycles after meas_valid.
REQ-022 A meas_valid arriving while the divider is busy SHALL restart it with the new operands; the pending result is discarded and duty_q8 holds.
REQ-023 Because high_cnt < period_cnt by construction, the quotient SHALL fit in 8 bits; any result above 255 SHALL saturate to 255.
REQ-024 A period_cnt saturated at all-ones SHALL still be divided; no special case is made for it.

Reset
REQ-025 Asserting rst_n low SHALL force, immediately and regardless of clk:
- FSM = IDLE;
- synchronizer, counters, high_cnt, period_cnt, duty_q8 = 0;
- meas_valid, duty_valid, signal_ok, stuck_level = 0;
- divider idle.
REQ-026 Reset asserted mid-measurement or mid-division SHALL discard all partial results; the first measurement after release requires two full rising edges.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enumeration;
- the default CNT_W and TIMEOUT constants;
- the DUTY_W = 8 constant.
REQ-028 The divider SHALL be a separate sub-module pwm_duty_div with start/busy/done handshake and parameterized operand width.

Verification
REQ-029 pwm_in 30 high / 70 low repeated -> from the second period on: meas_valid each period, high_cnt=30, period_cnt=100, duty_q8=76, duty_valid 9 cycles after meas_valid, signal_ok=1.
REQ-030 pwm_in 1 high / 9 low -> high_cnt=1, period_cnt=10, duty_q8=25.
REQ-031 pwm_in 3 high / 5 low (period shorter than divider latency) -> divider restarts on every meas_valid, no duty_valid issued, duty_q8 unchanged, high_cnt=3, period_cnt=8 each period.
REQ-032 Running signal, then pwm_in held high -> signal_ok clears TIMEOUT cycles after the last rising edge, stuck_level=1; repeat held low -> stuck_level=0.
REQ-033 rst_n pulsed low mid-period -> all outputs 0 at once; after release, first meas_valid only after two rising edges.
REQ-034 TIMEOUT set above 2^CNT_W, pwm_in static -> counter saturates at all-ones, no wrap, no spurious meas_valid.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block and its duty-cycle divider.
package pwm_capture_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 24;
  localparam int unsigned TIMEOUT_DEFAULT = 2_700_000;
  localparam int unsigned DUTY_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  // Clamp a quotient carrying one overflow bit to the duty range.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W:0] q);
    return q[DUTY_W] ? {DUTY_W{1'b1}} : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider computing sat((num << DUTY_W) / den), one quotient bit per cycle.
// A start while busy reloads the operands and drops the pending result.
module pwm_duty_div
  import pwm_capture_pkg::*;
#(
  parameter int unsigned OP_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [OP_W-1:0]   num_i,
  input  logic [OP_W-1:0]   den_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DUTY_W-1:0] quot_o
);

  localparam int unsigned QB = DUTY_W + 1;
  localparam int unsigned SW = $clog2(QB);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SW-1:0]     step_q, step_d;
  logic [OP_W-1:0]   rem_q, rem_d;
  logic [OP_W-1:0]   den_q, den_d;
  logic [QB-1:0]     shf_q, shf_d;
  logic [QB-1:0]     quo_q, quo_d;
  logic [DUTY_W-1:0] res_q, res_d;

  logic [OP_W:0]     trial;
  logic [OP_W:0]     diff;
  logic              take;
  logic [QB-1:0]     quo_nxt;

  always_comb begin
    trial   = {rem_q, shf_q[QB-1]};
    diff    = trial - {1'b0, den_q};
    take    = (trial >= {1'b0, den_q});
    quo_nxt = {quo_q[QB-2:0], take};

    busy_d = busy_q;
    done_d = 1'b0;
    step_d = step_q;
    rem_d  = rem_q;
    den_d  = den_q;
    shf_d  = shf_q;
    quo_d  = quo_q;
    res_d  = res_q;

    if (busy_q) begin
      rem_d  = OP_W'(take ? diff : trial);
      quo_d  = quo_nxt;
      shf_d  = shf_q << 1;
      step_d = step_q + SW'(1);
      if (step_q == SW'(QB - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_d  = sat_duty(quo_nxt);
      end
    end

    // Dividend is {num, 8'b0}: its top bits seed the remainder, the rest shift in.
    if (start_i) begin
      busy_d = 1'b1;
      step_d = '0;
      rem_d  = num_i >> 1;
      shf_d  = {num_i[0], {DUTY_W{1'b0}}};
      den_d  = den_i;
      quo_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      shf_q  <= '0;
      quo_q  <= '0;
      res_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      shf_q  <= shf_d;
      quo_q  <= quo_d;
      res_q  <= res_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = res_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time, period and duty of an asynchronous PWM input,
// with loss-of-signal detection after TIMEOUT cycles without an edge.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty_q8,
  output logic              duty_valid,
  output logic              signal_ok,
  output logic              stuck_level
);

  logic [2:0]       sync_q;
  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hlat_q, hlat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_q, meas_d;
  logic             ok_q, ok_d;
  logic             stuck_q, stuck_d;

  logic             lvl;
  logic             rise;
  logic             fall;
  logic             to_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             div_busy_unused;

  // sync_q[1] is the synchronized level, sync_q[2] its one-cycle delayed copy.
  assign lvl     = sync_q[1];
  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign to_hit  = (64'(cnt_q) >= 64'(TIMEOUT));
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hlat_d   = hlat_q;
    high_d   = high_q;
    period_d = period_q;
    meas_d   = 1'b0;
    ok_d     = ok_q;
    stuck_d  = stuck_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          state_d = ST_LOW;
          hlat_d  = cnt_q;
        end else if (to_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ok_d    = 1'b0;
          stuck_d = lvl;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d  = ST_HIGH;
          cnt_d    = CNT_W'(1);
          meas_d   = 1'b1;
          high_d   = hlat_q;
          period_d = cnt_q;
          ok_d     = 1'b1;
        end else if (to_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ok_d    = 1'b0;
          stuck_d = lvl;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hlat_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      meas_q   <= 1'b0;
      ok_q     <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], pwm_in};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hlat_q   <= hlat_d;
      high_q   <= high_d;
      period_q <= period_d;
      meas_q   <= meas_d;
      ok_q     <= ok_d;
      stuck_q  <= stuck_d;
    end
  end

  // Started with the values being latched, so duty_valid lands 9 cycles after meas_valid.
  pwm_duty_div #(
    .OP_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (meas_d),
    .num_i   (high_d),
    .den_i   (period_d),
    .busy_o  (div_busy_unused),
    .done_o  (duty_valid),
    .quot_o  (duty_q8)
  );

  assign meas_valid  = meas_q;
  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign signal_ok   = ok_q;
  assign stuck_level = stuck_q;

endmodule
